ram_access_ctrl: RTL and testbench

Host-side initiator for the dual-port `ram_chip`. It accepts independent write and read requests over valid/ready handshakes and drives the RAM's write and read ports with registered signals. It returns read data through a credit-protected response FIFO, so host backpressure never drops a RAM read. It also sequences `chip_en` through a drain state so the RAM is never disabled with reads in flight.

---
 rtl/ram_pkg.sv | 13 +
 rtl/rsp_fifo.sv | 50 +++++
 rtl/ram_access_ctrl.sv | 129 ++++++++++++
 tb/tb_ram_access_ctrl.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_pkg.sv
// Shared types and default widths for the ram_chip host-side controller.
package ram_pkg;

  localparam int DEF_DATA_W = 64;
  localparam int DEF_ADDR_W = 12;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

endpackage

// File: rtl/rsp_fifo.sv
// Synchronous response FIFO; pointers wrap naturally since DEPTH is a power of 2.
module rsp_fifo #(
  parameter  int W     = 64,
  parameter  int DEPTH = 4,
  localparam int CW    = $clog2(DEPTH + 1),
  localparam int PW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic          pop,
  input  logic [W-1:0]  din,
  output logic [W-1:0]  dout,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty
);

  logic [DEPTH-1:0][W-1:0] mem;
  logic [PW-1:0]           wr_ptr, rd_ptr;
  logic                    do_push, do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  // Storage is cleared too so rsp_data reads 0 out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem    <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/ram_access_ctrl.sv
// Host-side initiator for ram_chip: registered write/read ports, credit-protected
// read response FIFO, and a RUN/DRAIN sequencer so chip_en never drops with reads in flight.
module ram_access_ctrl
  import ram_pkg::*;
#(
  parameter  int DATA_W    = DEF_DATA_W,
  parameter  int ADDR_W    = DEF_ADDR_W,
  parameter  int RSP_DEPTH = 4,
  localparam int OW        = $clog2(RSP_DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_valid,
  output logic              rd_ready,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic              busy,
  output logic              err,
  output logic              ram_chip_en,
  output logic              ram_write,
  output logic              ram_read,
  output logic [ADDR_W-1:0] ram_wr_address,
  output logic [ADDR_W-1:0] ram_rd_address,
  output logic [DATA_W-1:0] ram_data_in,
  input  logic [DATA_W-1:0] ram_data_out,
  input  logic              ram_data_valid
);

  localparam logic [OW:0] DEPTH_L = (OW + 1)'(RSP_DEPTH);

  state_t          state, state_nxt;
  logic [OW-1:0]   outstanding;
  logic [OW-1:0]   fifo_count;
  logic            fifo_full, fifo_empty;
  logic            run, hazard, credit_ok;
  logic            wr_fire, rd_fire, rsp_fire;
  logic            dv_ok, rsp_push;

  assign run       = (state == RUN);
  assign hazard    = wr_valid && rd_valid && (wr_addr == rd_addr);
  // Every accepted read owns a FIFO slot from accept until it is popped.
  assign credit_ok = ({1'b0, outstanding} + {1'b0, fifo_count}) < DEPTH_L;

  assign wr_ready    = run;
  assign rd_ready    = run && credit_ok && !hazard;
  assign wr_fire     = wr_valid && wr_ready;
  assign rd_fire     = rd_valid && rd_ready;
  assign busy        = (state != IDLE);
  assign ram_chip_en = (state != IDLE);

  assign rsp_valid = !fifo_empty;
  assign rsp_fire  = rsp_valid && rsp_ready;
  assign dv_ok     = ram_data_valid && (outstanding != '0);
  assign rsp_push  = dv_ok && !fifo_full;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (en) state_nxt = RUN;
      RUN:   if (!en) state_nxt = DRAIN;
      DRAIN: begin
        if (en)                                      state_nxt = RUN;
        else if ((outstanding == '0) && fifo_empty)  state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      outstanding <= '0;
      err         <= 1'b0;
    end else begin
      case ({rd_fire, dv_ok})
        2'b10:   outstanding <= outstanding + 1'b1;
        2'b01:   outstanding <= outstanding - 1'b1;
        default: ;
      endcase
      // Data with nothing outstanding is dropped; flag it until reset.
      if (ram_data_valid && (outstanding == '0)) err <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ram_write      <= 1'b0;
      ram_read       <= 1'b0;
      ram_wr_address <= '0;
      ram_rd_address <= '0;
      ram_data_in    <= '0;
    end else begin
      ram_write <= wr_fire;
      ram_read  <= rd_fire;
      if (wr_fire) begin
        ram_wr_address <= wr_addr;
        ram_data_in    <= wr_data;
      end
      if (rd_fire) ram_rd_address <= rd_addr;
    end
  end

  rsp_fifo #(
    .W     (DATA_W),
    .DEPTH (RSP_DEPTH)
  ) u_rsp_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (rsp_push),
    .pop   (rsp_fire),
    .din   (ram_data_out),
    .dout  (rsp_data),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

endmodule

// File: tb/tb_ram_access_ctrl.sv
// Bench for ram_access_ctrl: directed steps plus a random phase, checked against a
// transaction-level memory model and an expected-response queue.
module tb_ram_access_ctrl;

  localparam int DW = 64;
  localparam int AW = 12;
  localparam int D  = 4;

  logic          clk = 1'b0, rst_n = 1'b0, en = 1'b0;
  logic          wr_valid = 1'b0, rd_valid = 1'b0, rsp_ready = 1'b0, inj = 1'b0;
  logic [AW-1:0] wr_addr = '0, rd_addr = '0;
  logic [DW-1:0] wr_data = '0;
  logic          wr_ready, rd_ready, rsp_valid, busy, err;
  logic          ram_chip_en, ram_write, ram_read, ram_data_valid;
  logic [AW-1:0] ram_wr_address, ram_rd_address;
  logic [DW-1:0] rsp_data, ram_data_in, ram_data_out;

  always #5 clk = ~clk;

  ram_access_ctrl dut (
    .clk(clk), .rst_n(rst_n), .en(en),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_addr(rd_addr),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .busy(busy), .err(err),
    .ram_chip_en(ram_chip_en), .ram_write(ram_write), .ram_read(ram_read),
    .ram_wr_address(ram_wr_address), .ram_rd_address(ram_rd_address),
    .ram_data_in(ram_data_in), .ram_data_out(ram_data_out), .ram_data_valid(ram_data_valid)
  );

  // Dual-port RAM: one-cycle registered read, data_valid the cycle after read.
  logic [DW-1:0] ram [0:(1<<AW)-1] = '{default: '0};
  logic          rv = 1'b0;
  logic [DW-1:0] rdout = '0;
  always @(posedge clk) begin
    rv <= ram_chip_en && ram_read;
    if (ram_chip_en && ram_read)  rdout <= ram[ram_rd_address];
    if (ram_chip_en && ram_write) ram[ram_wr_address] <= ram_data_in;
  end
  assign ram_data_out   = rdout;
  assign ram_data_valid = rv | inj;

  // Reference model state.
  logic [DW-1:0] ref_mem [0:(1<<AW)-1] = '{default: '0};
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] last_rsp = '0, prev_data = '0;
  logic          prev_hold = 1'b0;
  int            nchk = 0, nerr = 0, n_rd = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Sample handshakes just before the edge, update the model, then advance.
  task automatic tick();
    logic          wf, rf, pf;
    logic [DW-1:0] e;
    @(negedge clk);
    wf = wr_valid && wr_ready;
    rf = rd_valid && rd_ready;
    pf = rsp_valid && rsp_ready;
    if (wr_valid && rd_valid && (wr_addr == rd_addr)) chk("hazard_stall", 64'(rd_ready), 64'd0);
    if (prev_hold && rsp_valid) chk("rsp_stable", rsp_data, prev_data);
    prev_hold = rsp_valid && !rsp_ready;
    prev_data = rsp_data;
    if (pf) begin
      chk("rsp_expected", 64'(exp_q.size() != 0), 64'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("rsp_data", rsp_data, e);
        last_rsp = rsp_data;
      end
    end
    if (rf) begin
      exp_q.push_back(ref_mem[rd_addr]);
      n_rd++;
    end
    if (wf) ref_mem[wr_addr] = wr_data;
    chk("credit_bound", 64'(exp_q.size() <= D), 64'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_ctl"}, 64'({wr_ready, rd_ready, rsp_valid, busy, err, ram_chip_en, ram_write, ram_read}), 64'd0);
    chk({tag, "_addr"}, 64'({ram_wr_address, ram_rd_address}), 64'd0);
    chk({tag, "_din"}, ram_data_in, 64'd0);
    chk({tag, "_rsp"}, rsp_data, 64'd0);
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 60 && exp_q.size() != 0; i++) tick();
    chk(tag, 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    int base;
    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk_zero("reset");
    rst_n = 1'b1;
    tick();
    chk("idle_busy", 64'(busy), 64'd0);

    // Enable, then write and read back address 5
    en = 1'b1;
    tick();
    chk("run_state", 64'({busy, ram_chip_en, wr_ready}), 64'b111);
    wr_valid = 1'b1; wr_addr = 12'd5; wr_data = 64'hA1B2_C3D4_E5F6_7890;
    tick();
    wr_valid = 1'b0;
    chk("wr_port", 64'({ram_write, ram_wr_address}), 64'({1'b1, 12'd5}));
    chk("wr_data", ram_data_in, 64'hA1B2_C3D4_E5F6_7890);
    rd_valid = 1'b1; rd_addr = 12'd5;
    tick();
    rd_valid = 1'b0;
    chk("wr_pulse_end", 64'(ram_write), 64'd0);
    chk("rd_port", 64'({ram_read, ram_rd_address}), 64'({1'b1, 12'd5}));
    chk("lat_n1", 64'(rsp_valid), 64'd0);
    tick();
    chk("lat_n2", 64'(rsp_valid), 64'd0);
    tick();
    chk("lat_n3", 64'(rsp_valid), 64'd1);
    chk("rsp_a1b2", rsp_data, 64'hA1B2_C3D4_E5F6_7890);
    rsp_ready = 1'b1;
    drain("drain_first");

    // Same-address write and read in one cycle
    wr_valid = 1'b1; wr_addr = 12'd7; wr_data = 64'h1111;
    rd_valid = 1'b1; rd_addr = 12'd7;
    #1;
    chk("hazard_ready", 64'({wr_ready, rd_ready}), 64'b10);
    tick();
    wr_valid = 1'b0;
    #1;
    chk("hazard_release", 64'(rd_ready), 64'd1);
    tick();
    rd_valid = 1'b0;
    drain("drain_hazard");
    chk("hazard_data", last_rsp, 64'h1111);

    // Credit limit under backpressure
    for (int i = 0; i < 6; i++) begin
      wr_valid = 1'b1; wr_addr = AW'(i); wr_data = {$urandom, $urandom};
      tick();
    end
    wr_valid = 1'b0;
    rsp_ready = 1'b0;
    base = n_rd;
    rd_valid = 1'b1; rd_addr = '0;
    for (int i = 0; i < 10; i++) begin
      tick();
      rd_addr = AW'(n_rd - base);
    end
    chk("credit_accepts", 64'(n_rd - base), 64'd4);
    chk("credit_stall", 64'(rd_ready), 64'd0);
    rsp_ready = 1'b1;
    for (int i = 0; i < 40 && !((n_rd - base == 6) && exp_q.size() == 0); i++) begin
      tick();
      rd_addr = AW'(n_rd - base);
      if (n_rd - base >= 6) rd_valid = 1'b0;
    end
    rd_valid = 1'b0;
    chk("credit_total", 64'(n_rd - base), 64'd6);
    chk("credit_drained", 64'(exp_q.size()), 64'd0);

    // Random traffic over a small address window
    for (int i = 0; i < 400; i++) begin
      wr_valid  = 1'($urandom_range(1));
      wr_addr   = AW'($urandom_range(7));
      wr_data   = {$urandom, $urandom};
      rd_valid  = 1'($urandom_range(1));
      rd_addr   = AW'($urandom_range(7));
      rsp_ready = ($urandom_range(3) != 0);
      tick();
    end
    wr_valid = 1'b0; rd_valid = 1'b0; rsp_ready = 1'b1;
    drain("drain_random");
    chk("random_err", 64'(err), 64'd0);

    // en drops with 4 reads in flight
    rsp_ready = 1'b0;
    base = n_rd;
    rd_valid = 1'b1;
    for (int i = 0; i < 10 && (n_rd - base) < 4; i++) begin
      rd_addr = AW'($urandom_range(7));
      tick();
    end
    rd_valid = 1'b0;
    chk("drain_setup", 64'(n_rd - base), 64'd4);
    en = 1'b0;
    tick();
    chk("drain_ready", 64'({wr_ready, rd_ready}), 64'd0);
    repeat (3) tick();
    chk("drain_hold", 64'({busy, ram_chip_en}), 64'b11);
    rsp_ready = 1'b1;
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) begin
      chk("drain_busy", 64'({busy, ram_chip_en}), 64'b11);
      tick();
    end
    chk("drain_done", 64'(exp_q.size()), 64'd0);
    repeat (2) tick();
    chk("drain_idle", 64'({busy, ram_chip_en}), 64'b00);

    // Reset with 2 reads outstanding
    en = 1'b1;
    tick();
    rsp_ready = 1'b0;
    rd_valid = 1'b1; rd_addr = 12'd5;
    tick();
    rd_addr = 12'd3;
    tick();
    rd_valid = 1'b0;
    rst_n = 1'b0;
    en = 1'b0;
    #1;
    chk_zero("midreset");
    exp_q.delete();
    prev_hold = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("post_reset_rsp", 64'({rsp_valid, busy}), 64'd0);
    end

    // Unsolicited ram_data_valid
    en = 1'b1;
    tick();
    chk("err_clear", 64'(err), 64'd0);
    inj = 1'b1;
    tick();
    inj = 1'b0;
    chk("err_set", 64'(err), 64'd1);
    chk("err_fifo", 64'(rsp_valid), 64'd0);
    repeat (3) tick();
    chk("err_sticky", 64'({err, rsp_valid}), 64'b10);
    rst_n = 1'b0;
    #1;
    chk("err_reset", 64'(err), 64'd0);
    tick();
    rst_n = 1'b1;
    tick();

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
